// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the signals around the shared register-file write port.
//   master : pipeline/debug side (drives requests, observes grants/port)
//   slave  : the arbiter itself
//   Signals:
//     wb_we/wb_rd/wb_data        writeback request (RegWriteW/RDW/ResultW)
//     dbg_valid/dbg_addr/dbg_data debug write request, dbg_ready accepts it
//     rf_we/rf_a3/rf_wd3         register file WE3/A3/WD3
//     stall_req                  to hazard unit
//     init_busy                  clear sequence running
//     wb_drop                    sticky: a writeback write was discarded
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            dbg_valid;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic            dbg_ready;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic            stall_req;
  logic            init_busy;
  logic            wb_drop;

  modport master (
    output wb_we, wb_rd, wb_data, dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, rf_we, rf_a3, rf_wd3, stall_req, init_busy, wb_drop
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, rf_we, rf_a3, rf_wd3, stall_req, init_busy, wb_drop
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between the writeback path and
//   a debug/boot-loader requester. Writeback has priority; a debug requester
//   denied STARVE_LIMIT consecutive cycles causes a stall and a forced grant.
//   Port outputs are combinational (write lands on the presenting posedge).
//
//   Optional feature macro: REGFILE_CLEAR_ON_RESET_EN
//     When defined, reset enters a CLEAR sequence writing zero to x1..x31
//     (31 cycles) before normal operation.
//
//   Ports:
//     clk  - clock, all state on posedge
//     rst  - synchronous active-high reset
//     bus  - regfile_write_arbiter_if.slave (requests, port, status)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

`ifdef REGFILE_CLEAR_ON_RESET_EN
  localparam logic [1:0] RESET_STATE = ST_CLEAR;
`else
  localparam logic [1:0] RESET_STATE = ST_RUN;
`endif

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] starve_inc;
  logic             wb_drop_q, wb_drop_d;
`ifdef REGFILE_CLEAR_ON_RESET_EN
  logic [4:0]       clr_idx_q, clr_idx_d;
`endif

  logic             sel_we;
  logic [4:0]       sel_a3;
  logic [XLEN-1:0]  sel_wd;
  logic             sel_ready;
  logic             wb_req;

  // A writeback to x0 is not a real request; it must not block debug.
  assign wb_req     = bus.wb_we && (bus.wb_rd != 5'd0);
  assign starve_inc = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX
                                                   : starve_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wb_drop_d    = wb_drop_q;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    clr_idx_d    = clr_idx_q;
`endif
    sel_we       = 1'b0;
    sel_a3       = 5'd0;
    sel_wd       = '0;
    sel_ready    = 1'b0;

    case (state_q)
`ifdef REGFILE_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        sel_we    = 1'b1;
        sel_a3    = clr_idx_q;
        clr_idx_d = clr_idx_q + 5'd1;
        if (bus.wb_we) wb_drop_d = 1'b1;
        if (clr_idx_q == 5'd31) state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        if (wb_req) begin
          sel_we = 1'b1;
          sel_a3 = bus.wb_rd;
          sel_wd = bus.wb_data;
          if (bus.dbg_valid) begin
            starve_cnt_d = starve_inc;
            if (starve_inc == STARVE_MAX) state_d = ST_FORCE;
          end
        end else if (bus.dbg_valid) begin
          // Debug to x0 is acknowledged but never reaches the port.
          sel_we       = (bus.dbg_addr != 5'd0);
          sel_a3       = bus.dbg_addr;
          sel_wd       = bus.dbg_data;
          sel_ready    = 1'b1;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ST_FORCE: begin
        // Any writeback here was bubbled by the stall; record the loss.
        if (wb_req) wb_drop_d = 1'b1;
        if (bus.dbg_valid) begin
          sel_we    = (bus.dbg_addr != 5'd0);
          sel_a3    = bus.dbg_addr;
          sel_wd    = bus.dbg_data;
          sel_ready = 1'b1;
        end
        starve_cnt_d = '0;
        state_d      = ST_RUN;
      end
      default: begin
        state_d      = RESET_STATE;
        starve_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      starve_cnt_q <= '0;
      wb_drop_q    <= 1'b0;
`ifdef REGFILE_CLEAR_ON_RESET_EN
      clr_idx_q    <= 5'd1;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wb_drop_q    <= wb_drop_d;
`ifdef REGFILE_CLEAR_ON_RESET_EN
      clr_idx_q    <= clr_idx_d;
`endif
    end
  end

  // Port is held quiet during reset regardless of state.
  assign bus.rf_we     = sel_we && !rst;
  assign bus.rf_a3     = rst ? 5'd0 : sel_a3;
  assign bus.rf_wd3    = rst ? '0 : sel_wd;
  assign bus.dbg_ready = sel_ready && !rst;
  assign bus.stall_req = (state_q != ST_RUN);
  assign bus.wb_drop   = wb_drop_q;
`ifdef REGFILE_CLEAR_ON_RESET_EN
  assign bus.init_busy = (state_q == ST_CLEAR);
`else
  assign bus.init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: remaining clear cycles, forced-grant pending flag,
  // count of consecutive denied debug cycles, sticky drop flag.
  int m_clear_left = 0;
  bit m_force      = 0;
  int m_starve     = 0;
  bit m_drop       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
`ifdef REGFILE_CLEAR_ON_RESET_EN
    m_clear_left = 31;
`else
    m_clear_left = 0;
`endif
    m_force  = 0;
    m_starve = 0;
    m_drop   = 0;
  endtask

  // One clock: drive, compare combinational outputs, then advance the model.
  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd,
                       output bit granted);
    bit e_we, e_rdy, e_stall, e_busy;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    bit wb_real;
    @(negedge clk);
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = wd;
    bus.dbg_valid = dv; bus.dbg_addr = da; bus.dbg_data = dd;
    #1;
    wb_real = we && (rd != 0);
    e_we = 0; e_rdy = 0; e_a3 = 0; e_wd = 0;
    e_busy  = (m_clear_left > 0);
    e_stall = (m_clear_left > 0) || m_force;
    if (m_clear_left > 0) begin
      e_we = 1; e_a3 = 5'(32 - m_clear_left); e_wd = 0;
    end else if (m_force || !wb_real) begin
      if (dv) begin
        e_rdy = 1; e_we = (da != 0); e_a3 = da; e_wd = dd;
      end
    end else begin
      e_we = 1; e_a3 = rd; e_wd = wd;
    end
    check("rf_we", 32'(bus.rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_a3", 32'(bus.rf_a3), 32'(e_a3));
      check("rf_wd3", bus.rf_wd3, e_wd);
    end
    check("dbg_ready", 32'(bus.dbg_ready), 32'(e_rdy));
    check("stall_req", 32'(bus.stall_req), 32'(e_stall));
    check("init_busy", 32'(bus.init_busy), 32'(e_busy));
    check("wb_drop", 32'(bus.wb_drop), 32'(m_drop));
    granted = e_rdy;
    @(posedge clk);
    if (m_clear_left > 0) begin
      if (we) m_drop = 1;
      m_clear_left--;
    end else if (m_force) begin
      if (wb_real) m_drop = 1;
      m_force = 0; m_starve = 0;
    end else if (wb_real && dv) begin
      m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (m_starve == LIMIT) m_force = 1;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1;
      bus.wb_we = 1'($urandom); bus.wb_rd = 5'($urandom); bus.wb_data = $urandom;
      bus.dbg_valid = 1'($urandom); bus.dbg_addr = 5'($urandom); bus.dbg_data = $urandom;
      #1;
      check("rst_rf_we", 32'(bus.rf_we), 0);
      check("rst_rf_a3", 32'(bus.rf_a3), 0);
      check("rst_rf_wd3", bus.rf_wd3, 0);
      check("rst_dbg_ready", 32'(bus.dbg_ready), 0);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  bit g;
  bit pend;
  logic [4:0]  p_addr;
  logic [31:0] p_data;

  initial begin
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.dbg_valid = 0; bus.dbg_addr = 0; bus.dbg_data = 0;

    do_reset(2);
    // Clear sequence (if built in) is checked by the model; idle traffic here.
    while (m_clear_left > 0) cycle(0, 0, 0, 0, 0, 0, g);

    // Plain writeback, then plain debug write.
    cycle(1, 5, 32'h0000_000B, 0, 0, 0, g);
    cycle(0, 0, 0, 1, 4, 32'h2, g);
    check("dbg_grant_idle", 32'(g), 1);

    // Starvation: four denied cycles, then forced grant with wb dropped.
    for (int i = 0; i < LIMIT; i++) cycle(1, 6, 32'h66, 1, 10, 32'hA5, g);
    cycle(0, 0, 0, 1, 10, 32'hA5, g);
    check("forced_grant", 32'(g), 1);
    cycle(0, 0, 0, 0, 0, 0, g);

    // Forced grant while a stray writeback arrives: writeback lost, drop sticks.
    for (int i = 0; i < LIMIT; i++) cycle(1, 6, 32'h77, 1, 2, 32'h22, g);
    cycle(1, 1, 32'h11, 1, 2, 32'h22, g);
    cycle(0, 0, 0, 0, 0, 0, g);
    check("drop_sticky", 32'(bus.wb_drop), 1);

    // Debug to x0 is acknowledged, wb to x0 does not block debug.
    cycle(0, 0, 0, 1, 0, 32'h55, g);
    cycle(1, 0, 32'h99, 1, 3, 32'h33, g);
    check("x0_wb_nonblocking", 32'(g), 1);

    // Reset clears the sticky drop, then randomized traffic.
    do_reset(1);
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      logic we;
      if (c == 1500) begin
        do_reset(1 + int'($urandom_range(0, 1)));
        pend = 0;
      end
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend = 1; p_addr = 5'($urandom); p_data = $urandom;
      end
      if (m_force && pend && ($urandom_range(0, 3) == 0)) pend = 0;
      we = m_force ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cycle(we, 5'($urandom), $urandom, pend, p_addr, p_data, g);
      if (g) pend = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (A3/WD3/WE3) of the decode-stage register file.
- Shares that port between the pipeline writeback path (RegWriteW/RDW/ResultW) and a debug/boot-loader requester that uses a valid/ready handshake.
- Writeback normally has priority. If the debug requester is starved too long, the block raises stall_req to the hazard unit and forces a debug grant.
- Optionally runs a post-reset clear sequence that zeroes x1..x31 before the pipeline starts.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before a forced grant (1..15).
- CNT_W, 4, width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- wb_we  input  1  writeback write enable (RegWriteW).
- wb_rd  input  5  writeback destination (RDW).
- wb_data  input  XLEN  writeback data (ResultW).
- dbg_valid  input  1  debug write request.
- dbg_addr  input  5  debug destination register.
- dbg_data  input  XLEN  debug write data.
- dbg_ready  output  1  debug request accepted this cycle.
- rf_we  output  1  to register file WE3.
- rf_a3  output  5  to register file A3.
- rf_wd3  output  XLEN  to register file WD3.
- stall_req  output  1  to hazard unit: freeze F/D/E and bubble the W-stage write.
- init_busy  output  1  clear sequence in progress.
- wb_drop  output  1  sticky: a writeback write was discarded.

Behaviour:
- State register has three states: CLEAR, RUN, FORCE. A cycle with rst=1 loads the reset state and clears the remaining registers:
  - starve_cnt = 0
  - clr_idx = 1
  - wb_drop = 0
- Reset state is CLEAR when the optional feature is compiled in, RUN otherwise.
- In any cycle with rst=1: rf_we=0, dbg_ready=0, rf_a3=0, rf_wd3=0.
- Port outputs (rf_*, dbg_ready) are combinational from state and inputs, with zero added latency: the write lands on the same posedge the requester presents it.
- stall_req = (state != RUN); init_busy = (state == CLEAR). Both are decoded from the state register only.
- Writes to register 0 are never driven: rf_we=0 whenever the selected address is 0, and the requester is still considered served.
- RUN:
  - wb_we=1 and wb_rd!=0: select writeback. dbg_ready=0. starve_cnt increments if dbg_valid=1, saturating at STARVE_LIMIT.
  - Otherwise, if dbg_valid=1: select debug. dbg_ready=1, starve_cnt cleared.
  - Otherwise rf_we=0 and starve_cnt is cleared.
  - If starve_cnt would reach STARVE_LIMIT this cycle, the next state is FORCE.
- FORCE:
  - stall_req=1. The hazard unit guarantees wb_we=0 from the first FORCE cycle onward.
  - If dbg_valid=1: grant debug (dbg_ready=1), clear starve_cnt, next state RUN.
  - If wb_we=1 and wb_rd!=0 arrives anyway: debug still wins, the writeback is discarded, and wb_drop sets and holds until rst.
  - If dbg_valid drops while in FORCE: clear starve_cnt, next state RUN, no grant.
- dbg_addr and dbg_data must stay stable while dbg_valid=1 and dbg_ready=0. A request is consumed on a cycle with dbg_valid && dbg_ready.
- Simultaneous wb write and dbg write to the same register in RUN: writeback wins. The debug request stays pending, so it lands later and its value is final.

Optional Feature:
- Macro: REGFILE_CLEAR_ON_RESET_EN
- Defined:
  - Reset enters CLEAR. Each cycle drives rf_we=1, rf_a3=clr_idx, rf_wd3=0, then increments clr_idx.
  - After clr_idx=31 is written, the next state is RUN. CLEAR therefore lasts exactly 31 cycles.
  - In CLEAR: dbg_ready=0, and any wb_we=1 is discarded and sets wb_drop.
  - rst asserted mid-CLEAR restarts the sequence at clr_idx=1.
- Undefined:
  - CLEAR state and clr_idx are absent. Reset enters RUN, and init_busy is tied to 0.

Test Plan:
- Clear enabled, rst high 2 cycles then low → init_busy=1 and stall_req=1 for 31 cycles; rf_a3 steps 1..31 with rf_wd3=0 and rf_we=1; RUN on cycle 32.
- RUN, wb_we=1, wb_rd=5, wb_data=0x0000000B, dbg_valid=0 → same cycle rf_we=1, rf_a3=5, rf_wd3=0x0000000B, dbg_ready=0.
- RUN, wb_we=0, dbg_valid=1, dbg_addr=4, dbg_data=0x2 → same cycle dbg_ready=1, rf_a3=4, rf_wd3=0x2; starve_cnt=0.
- STARVE_LIMIT=4, wb_we=1 to x6 every cycle, dbg_valid=1 to x10 → dbg_ready=0 for 4 cycles; stall_req=1 on cycle 5; bench drops wb_we; dbg granted cycle 5 (rf_a3=10); stall_req=0 on cycle 6.
- In FORCE with wb_we=1 to x1 and dbg_valid=1 to x2 → debug written, x1 write lost, wb_drop=1 and held until rst.
- dbg_valid=1, dbg_addr=0, wb idle → dbg_ready=1, rf_we=0; a wb_we=1 with wb_rd=0 does not block a pending debug request.
